// File: rtl/ysyx_22050710_lsu_axil_master_pkg.sv
// Shared definitions for the LSU AXI-lite master: FSM encoding, AXI response
// codes and protection attribute.
package ysyx_22050710_lsu_axil_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RESP    = 3'd5
    } lsu_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    function automatic logic axi_resp_is_err(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/ysyx_22050710_lsu_axil_master.sv
// Single-outstanding LSU to AXI-lite master bridge. One request is turned into
// either an AR/R or an AW+W/B exchange and answered with one LSU response.
module ysyx_22050710_lsu_axil_master
    import ysyx_22050710_lsu_axil_master_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_aclk,
    input  logic                  i_arsetn,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wen,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [STRB_WIDTH-1:0] i_req_wstrb,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_err,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic [2:0]            o_awprot,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [STRB_WIDTH-1:0] o_wstrb,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    input  logic [1:0]            i_bresp,
    output logic                  o_arvalid,
    input  logic                  i_arready,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    output logic [2:0]            o_arprot,
    input  logic                  i_rvalid,
    output logic                  o_rready,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_rresp
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  aw_done_q, w_done_q;

    logic req_fire, ar_fire, r_fire, aw_fire, w_fire, b_fire, resp_fire;
    logic aw_done_d, w_done_d, wr_both_done;

    assign req_fire  = i_req_valid & o_req_ready;
    assign ar_fire   = o_arvalid & i_arready;
    assign r_fire    = i_rvalid & o_rready;
    assign aw_fire   = o_awvalid & i_awready;
    assign w_fire    = o_wvalid & i_wready;
    assign b_fire    = i_bvalid & o_bready;
    assign resp_fire = o_resp_valid & i_resp_ready;

    // A channel counts as done if it completed earlier or completes this cycle.
    assign aw_done_d    = aw_done_q | aw_fire;
    assign w_done_d     = w_done_q | w_fire;
    assign wr_both_done = aw_done_d & w_done_d;

    // State register
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = req_fire ? (i_req_wen ? ST_WR_REQ : ST_RD_ADDR) : ST_IDLE;
            ST_RD_ADDR: state_d = ar_fire ? ST_RD_DATA : ST_RD_ADDR;
            ST_RD_DATA: state_d = r_fire ? ST_RESP : ST_RD_DATA;
            ST_WR_REQ:  state_d = wr_both_done ? ST_WR_RESP : ST_WR_REQ;
            ST_WR_RESP: state_d = b_fire ? ST_RESP : ST_WR_RESP;
            ST_RESP:    state_d = resp_fire ? ST_IDLE : ST_RESP;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        o_req_ready  = 1'b0;
        o_arvalid    = 1'b0;
        o_rready     = 1'b0;
        o_awvalid    = 1'b0;
        o_wvalid     = 1'b0;
        o_bready     = 1'b0;
        o_resp_valid = 1'b0;
        case (state_q)
            ST_IDLE:    o_req_ready = 1'b1;
            ST_RD_ADDR: o_arvalid   = 1'b1;
            ST_RD_DATA: o_rready    = 1'b1;
            ST_WR_REQ: begin
                o_awvalid = ~aw_done_q;
                o_wvalid  = ~w_done_q;
            end
            ST_WR_RESP: o_bready     = 1'b1;
            ST_RESP:    o_resp_valid = 1'b1;
            default:    o_req_ready  = 1'b0;
        endcase
    end

    // AW/W completion flags, cleared whenever the write phase is not pending
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if ((state_q == ST_WR_REQ) && !wr_both_done) begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end else begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end
    end

    // Request capture; held constant for the whole transaction
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (req_fire) begin
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
            wstrb_q <= i_req_wstrb;
        end else begin
            addr_q  <= addr_q;
            wdata_q <= wdata_q;
            wstrb_q <= wstrb_q;
        end
    end

    // Response capture from R or B
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (r_fire) begin
            rdata_q <= i_rdata;
            err_q   <= axi_resp_is_err(i_rresp);
        end else if (b_fire) begin
            rdata_q <= '0;
            err_q   <= axi_resp_is_err(i_bresp);
        end else begin
            rdata_q <= rdata_q;
            err_q   <= err_q;
        end
    end

    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;
    assign o_awaddr     = addr_q;
    assign o_araddr     = addr_q;
    assign o_wdata      = wdata_q;
    assign o_wstrb      = wstrb_q;
    assign o_awprot     = AXI_PROT_DEFAULT;
    assign o_arprot     = AXI_PROT_DEFAULT;

endmodule

// File: doc/ysyx_22050710_lsu_axil_master.md
YSYX_22050710_LSU_AXIL_MASTER -- requirements
Module: ysyx_22050710_lsu_axil_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, byte-strobe width.
REQ-004 SHALL have port i_aclk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_arsetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have LSU request ports: i_req_valid in 1, o_req_ready out 1, i_req_wen in 1 (1=store), i_req_addr in ADDR_WIDTH, i_req_wdata in DATA_WIDTH, i_req_wstrb in STRB_WIDTH.
REQ-007 SHALL have LSU response ports: o_resp_valid out 1, i_resp_ready in 1, o_resp_rdata out DATA_WIDTH, o_resp_err out 1 (AXI resp != OKAY).
REQ-008 SHALL have AXI-lite write master ports: o_awvalid, i_awready, o_awaddr[ADDR_WIDTH], o_awprot[3]; o_wvalid, i_wready, o_wdata[DATA_WIDTH], o_wstrb[STRB_WIDTH]; i_bvalid, o_bready, i_bresp[2].
REQ-009 SHALL have AXI-lite read master ports: o_arvalid, i_arready, o_araddr[ADDR_WIDTH], o_arprot[3]; i_rvalid, o_rready, i_rdata[DATA_WIDTH], i_rresp[2].

Function
REQ-010 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP; one transaction outstanding at a time.
REQ-011 SHALL assert o_req_ready only in IDLE; on req fire latch addr/wdata/wstrb/wen and go to WR_REQ if wen else RD_ADDR.
REQ-012 SHALL hold o_arvalid=1 in RD_ADDR with o_araddr from latched addr; ar fire -> RD_DATA.
REQ-013 SHALL hold o_rready=1 in RD_DATA; r fire latches i_rdata into o_resp_rdata, err=(i_rresp!=0), -> RESP.
REQ-014 SHALL in WR_REQ assert o_awvalid and o_wvalid together; each drops independently after its own handshake (aw_done/w_done flags); both done -> WR_RESP.
REQ-015 SHALL tolerate slaves accepting W only after AW, and AW/W firing in the same cycle.
REQ-016 SHALL hold o_bready=1 in WR_RESP; b fire sets err=(i_bresp!=0), o_resp_rdata=0, -> RESP.
REQ-017 SHALL hold o_resp_valid=1 in RESP with stable data/err until i_resp_ready; fire -> IDLE.
REQ-018 SHALL drive o_awprot=o_arprot=3'b000 constant.
REQ-019 SHALL keep AXI address/data/strobe outputs stable while their valid is high (AXI rule: valid never drops without handshake).
REQ-020 SHALL give minimum latency req fire -> resp valid of 3 cycles for a zero-wait slave responding one cycle after AR/W fire.
REQ-021 SHALL ignore i_rvalid/i_bvalid outside RD_DATA/WR_RESP (ready low).

Reset
REQ-022 SHALL on i_arsetn low immediately force state IDLE, clear aw_done/w_done, all valid/ready outputs 0 except o_req_ready (1 after reset, IDLE), o_resp_rdata=0, o_resp_err=0.
REQ-023 SHALL abandon any in-flight transaction on reset mid-operation with no response issued.

Structure
REQ-024 SHALL place FSM state encodings and AXI resp codes (OKAY=2'b00) in the shared axi_defines include.
REQ-025 SHALL be a single module, optionally using the codebase Reg primitive for output registers; no further sub-module.

Verification
REQ-026 Read: req addr 0x8000_0010 wen=0, slave rdata 0x1122_3344_5566_7788 rresp=0 -> one AR at 0x8000_0010, resp rdata 0x1122334455667788 err=0, 3-cycle latency.
REQ-027 Write: addr 0x8000_0020 wdata 0xDEAD_BEEF wstrb 0x0F, slave W-after-AW -> AW then W fire in order, one B, resp err=0.
REQ-028 Backpressure: awready low 4 cycles, i_resp_ready low 3 cycles -> awvalid/awaddr stable, resp held stable, no second request accepted.
REQ-029 Error: rresp=2'b10 on a read -> o_resp_err=1; bresp=2'b11 on a write -> o_resp_err=1.
REQ-030 Reset mid-write after AW fire before W -> all valids 0 asynchronously, state IDLE, next read completes normally.
